// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the synchronous FIFO and its controller.
package fifo_pkg;

    // Accepted operation for one cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Default geometry shared with the FIFO top level
    localparam int DEFAULT_ADDR_BITS = 3;
    localparam int DEFAULT_DEPTH     = 1 << DEFAULT_ADDR_BITS;
    localparam int DEFAULT_AF_TH     = 6;
    localparam int DEFAULT_AE_TH     = 2;

endpackage : fifo_pkg

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the synchronous FIFO. Drives the storage
// write enable and addresses, and reports occupancy, full/empty, almost
// flags and sticky overflow/underflow errors.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AddrBits      = DEFAULT_ADDR_BITS,
    parameter int AlmostFullTh  = DEFAULT_AF_TH,
    parameter int AlmostEmptyTh = DEFAULT_AE_TH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_i,
    input  logic                rd_i,
    input  logic                clr_err_i,
    output logic                wr_en_o,
    output logic [AddrBits-1:0] w_addr_o,
    output logic [AddrBits-1:0] r_addr_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [AddrBits:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam logic [AddrBits:0]   DEPTH   = {1'b1, {AddrBits{1'b0}}};
    localparam logic [AddrBits:0]   AF_TH   = (AddrBits+1)'(AlmostFullTh);
    localparam logic [AddrBits:0]   AE_TH   = (AddrBits+1)'(AlmostEmptyTh);
    localparam logic [AddrBits:0]   CNT_ONE = (AddrBits+1)'(1);
    localparam logic [AddrBits-1:0] PTR_ONE = AddrBits'(1);

    // Thresholds must leave a gap so the almost flags never overlap
    if (AlmostEmptyTh >= AlmostFullTh) begin : g_bad_thresholds
        $error("fifo_ctrl: AlmostEmptyTh must be less than AlmostFullTh");
    end

    logic [AddrBits-1:0] r_waddr;
    logic [AddrBits-1:0] r_raddr;
    logic [AddrBits:0]   r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_afull;
    logic                r_aempty;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_push_ok;
    logic                w_pop_ok;
    fifo_op_e            w_op;
    logic [AddrBits:0]   w_count_nxt;

    // A full FIFO still takes a push when a pop frees the head in the same
    // cycle: storage reads are combinational, so the old word leaves before
    // the edge overwrites that address.
    assign w_push_ok = wr_i && (!r_full || rd_i);
    assign w_pop_ok  = rd_i && !r_empty;
    assign w_op      = fifo_op_e'({w_push_ok, w_pop_ok});

    // Next occupancy from the accepted operation
    always_comb begin
        // NOTE: default first so every path assigns w_count_nxt; otherwise a latch is inferred.
        w_count_nxt = r_count;
        unique case (w_op)
            OP_PUSH: w_count_nxt = r_count + CNT_ONE;
            OP_POP:  w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and flags; flags come from the next-state count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_waddr  <= '0;
            r_raddr  <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            if (w_push_ok) r_waddr <= r_waddr + PTR_ONE;
            if (w_pop_ok)  r_raddr <= r_raddr + PTR_ONE;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == DEPTH);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= AF_TH);
            r_aempty <= (w_count_nxt <= AE_TH);
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_i && !w_push_ok) || (r_overflow  && !clr_err_i);
            r_underflow <= (rd_i && !w_pop_ok)  || (r_underflow && !clr_err_i);
        end
    end

    assign wr_en_o        = w_push_ok;
    assign w_addr_o       = r_waddr;
    assign r_addr_o       = r_raddr;
    assign count_o        = r_count;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_afull;
    assign almost_empty_o = r_aempty;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed walk through the main
// scenarios, then randomized traffic against an occupancy-level model.
module tb_fifo_ctrl;

    localparam int ADDR_BITS = 3;
    localparam int DEPTH     = 8;
    localparam int AF_TH     = 6;
    localparam int AE_TH     = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 wr_i = 1'b0;
    logic                 rd_i = 1'b0;
    logic                 clr_err_i = 1'b0;
    logic                 wr_en_o;
    logic [ADDR_BITS-1:0] w_addr_o;
    logic [ADDR_BITS-1:0] r_addr_o;
    logic                 full_o;
    logic                 empty_o;
    logic                 almost_full_o;
    logic                 almost_empty_o;
    logic [ADDR_BITS:0]   count_o;
    logic                 overflow_o;
    logic                 underflow_o;

    fifo_ctrl #(
        .AddrBits     (ADDR_BITS),
        .AlmostFullTh (AF_TH),
        .AlmostEmptyTh(AE_TH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_i          (wr_i),
        .rd_i          (rd_i),
        .clr_err_i     (clr_err_i),
        .wr_en_o       (wr_en_o),
        .w_addr_o      (w_addr_o),
        .r_addr_o      (r_addr_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .almost_empty_o(almost_empty_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: occupancy and pointer positions as plain integers
    int m_count = 0;
    int m_wp    = 0;
    int m_rp    = 0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("w_addr",       32'(w_addr_o),       32'(m_wp));
        check("r_addr",       32'(r_addr_o),       32'(m_rp));
        check("count",        32'(count_o),        32'(m_count));
        check("full",         32'(full_o),         32'(m_count == DEPTH));
        check("empty",        32'(empty_o),        32'(m_count == 0));
        check("almost_full",  32'(almost_full_o),  32'(m_count >= AF_TH));
        check("almost_empty", 32'(almost_empty_o), 32'(m_count <= AE_TH));
        check("overflow",     32'(overflow_o),     32'(m_ovf));
        check("underflow",    32'(underflow_o),    32'(m_unf));
    endtask

    // One clock cycle: drive at the falling edge, check the combinational
    // write enable, let the rising edge happen, then check registered state.
    task automatic cycle(input bit w, input bit r, input bit c, input bit rst);
        bit push_ok;
        bit pop_ok;
        wr_i      = w;
        rd_i      = r;
        clr_err_i = c;
        rst_i     = rst;
        #1;
        push_ok = w && ((m_count < DEPTH) || r);
        pop_ok  = r && (m_count > 0);
        if (!rst) check("wr_en", 32'(wr_en_o), 32'(push_ok));
        @(posedge clk_i);
        if (rst) begin
            m_count = 0;
            m_wp    = 0;
            m_rp    = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            if (push_ok) m_wp = (m_wp + 1) % DEPTH;
            if (pop_ok)  m_rp = (m_rp + 1) % DEPTH;
            m_count = m_count + int'(push_ok) - int'(pop_ok);
            m_ovf   = (w && !push_ok) || (m_ovf && !c);
            m_unf   = (r && !pop_ok)  || (m_unf && !c);
        end
        #1;
        check_outputs();
        @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);

        // Reset then idle
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_wr_en", 32'(wr_en_o), 32'd0);

        // Eight pushes fill the FIFO and wrap the write pointer
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("fill_full",  32'(full_o),   32'd1);
        check("fill_wrap",  32'(w_addr_o), 32'd0);
        check("fill_count", 32'(count_o),  32'd8);

        // Ninth push alone is rejected, then the error is cleared
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_set",   32'(overflow_o), 32'd1);
        check("ovf_count", 32'(count_o),    32'd8);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_clr",   32'(overflow_o), 32'd0);

        // Push+pop while full for three cycles
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("both_full_w", 32'(w_addr_o), 32'd3);
        check("both_full_r", 32'(r_addr_o), 32'd3);
        check("both_full_f", 32'(full_o),   32'd1);

        // Drain, then push+pop on empty accepts only the push
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("drained", 32'(empty_o), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("both_empty_unf", 32'(underflow_o), 32'd1);
        check("both_empty_cnt", 32'(count_o),     32'd1);
        check("both_empty_w",   32'(w_addr_o),    32'd4);
        check("both_empty_r",   32'(r_addr_o),    32'd3);

        // Clear and new error in the same cycle: the flag stays set
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("set_wins_ovf", 32'(overflow_o), 32'd1);
        check("clr_unf",      32'(underflow_o), 32'd0);

        // Reset mid-operation at count 5 while pushing
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(count_o), 32'd5);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_cnt",   32'(count_o),  32'd0);
        check("rst_empty", 32'(empty_o),  32'd1);
        check("rst_w",     32'(w_addr_o), 32'd0);

        // Randomized traffic in phases biased toward filling or draining
        for (int ph = 0; ph < 16; ph++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (ph % 2 == 0) ? 80 : 25;
            rd_pct = (ph % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 150; i++) begin
                bit w;
                bit r;
                bit c;
                bit rs;
                w  = ($urandom_range(99) < wr_pct);
                r  = ($urandom_range(99) < rd_pct);
                c  = ($urandom_range(99) < 6);
                rs = ($urandom_range(999) < 4);
                cycle(w, r, c, rs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_ctrl
